// File: rtl/addsub_acc_unit.sv
// addsub_acc_unit: registered two's-complement add/sub/accumulate with valid/ready,
// optional saturation and sticky overflow.  Rev 1.0
`default_nettype none

module addsub_acc_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             sat,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ofFlag,
  output logic             zero,
  output logic             neg,
  output logic             ofSticky
);

  localparam logic [1:0]       c_op_sub  = 2'b00;
  localparam logic [1:0]       c_op_load = 2'b11;
  localparam logic [WIDTH-1:0] c_sat_max = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_sat_min = {1'b1, {(WIDTH-1){1'b0}}};

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_of;
  logic             r_zero;
  logic             r_neg;
  logic             r_sticky;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_raw;
  logic             w_is_sub;
  logic             w_of;
  logic [WIDTH-1:0] w_final;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Accumulate mode feeds the accumulator as operand A and input1 as operand B.
  always_comb begin
    w_a      = input1;
    w_b      = input2;
    w_is_sub = (op == c_op_sub);
    w_raw    = '0;
    w_of     = 1'b0;
    w_final  = '0;
    if (op[1]) begin
      w_a = r_acc;
      w_b = input1;
    end
    if (w_is_sub) begin
      w_raw = w_a - w_b;
      w_of  = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_raw[WIDTH-1] != w_a[WIDTH-1]);
    end else begin
      w_raw = w_a + w_b;
      w_of  = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_raw[WIDTH-1] != w_a[WIDTH-1]);
    end
    if (op == c_op_load) begin
      w_of    = 1'b0;
      w_final = input1;
    end else if (sat && w_of) begin
      w_final = w_a[WIDTH-1] ? c_sat_min : c_sat_max;
    end else begin
      w_final = w_raw;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_of        <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_sticky    <= 1'b0;
      r_acc       <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_result    <= w_final;
        r_of        <= w_of;
        r_zero      <= (w_final == '0);
        r_neg       <= w_final[WIDTH-1];
        if (op[1]) begin
          r_acc <= w_final;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // A new overflow outranks a clear on the same edge.
      if (w_accept && w_of) begin
        r_sticky <= 1'b1;
      end else if (clr_sticky) begin
        r_sticky <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ofFlag    = r_of;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign ofSticky  = r_sticky;

endmodule

`default_nettype wire
